// File: rtl/perspective_divide.sv
// Perspective-divide stage: clip-space (x,y,z,w) to NDC (x/w,y/w,z/w)
// with one time-shared pipelined unsigned divider and valid/ready handshakes.
module fixed_divide (
  input  logic        clk,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic [25:0] quotient
);
  // One restoring-division step per stage: integer bit first, then 25 fraction bits.
  localparam int STAGES = 26;

  logic [23:0] rem_q [STAGES];
  logic [23:0] div_q [STAGES];
  logic [25:0] quo_q [STAGES];
  logic [24:0] src_t [STAGES];
  logic [23:0] src_d [STAGES];
  logic [25:0] src_q [STAGES];
  logic [24:0] diff  [STAGES];

  always_comb begin
    src_t[0] = {1'b0, dividend};
    src_d[0] = divisor;
    src_q[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      src_t[i] = {rem_q[i-1], 1'b0};
      src_d[i] = div_q[i-1];
      src_q[i] = quo_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      diff[i] = src_t[i] - {1'b0, src_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      div_q[i] <= src_d[i];
      if (src_t[i] >= {1'b0, src_d[i]}) begin
        rem_q[i] <= diff[i][23:0];
        quo_q[i] <= {src_q[i][24:0], 1'b1};
      end else begin
        rem_q[i] <= src_t[i][23:0];
        quo_q[i] <= {src_q[i][24:0], 1'b0};
      end
    end
  end

  assign quotient = quo_q[STAGES-1];
endmodule

module perspective_divide #(
  parameter int DIV_LATENCY = 26
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        vertex_valid_in,
  output logic        vertex_ready_out,
  input  logic [23:0] x_in,
  input  logic [23:0] y_in,
  input  logic [23:0] z_in,
  input  logic [23:0] w_in,
  output logic        ndc_valid_out,
  input  logic        ndc_ready_in,
  output logic [26:0] ndc_x_out,
  output logic [26:0] ndc_y_out,
  output logic [26:0] ndc_z_out,
  output logic [2:0]  clip_out,
  output logic        degenerate_out
);
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [2:0]  sgn;
  logic [2:0]  sat;
  logic [23:0] mag_y;
  logic [23:0] mag_z;
  logic [23:0] op_a;
  logic [23:0] op_d;
  logic        iss_valid;
  logic [1:0]  iss_axis;
  logic [DIV_LATENCY-1:0][2:0] tag;
  logic [25:0] quotient;

  logic        accept;
  logic        degen_in;
  logic [23:0] abs_x;
  logic [23:0] abs_y;
  logic [23:0] abs_z;
  logic        cap_valid;
  logic [1:0]  cap_axis;
  logic        cap_sat;
  logic        cap_sgn;
  logic [26:0] cap_ext;
  logic [26:0] cap_val;

  function automatic logic [23:0] absv(input logic [23:0] v);
    return v[23] ? (~v + 24'd1) : v;
  endfunction

  assign abs_x    = absv(x_in);
  assign abs_y    = absv(y_in);
  assign abs_z    = absv(z_in);
  assign degen_in = w_in[23] || (w_in == 24'd0);
  assign accept   = vertex_valid_in && vertex_ready_out;

  assign cap_valid = tag[DIV_LATENCY-1][2];
  assign cap_axis  = tag[DIV_LATENCY-1][1:0];

  always_comb begin
    cap_sat = 1'b0;
    cap_sgn = 1'b0;
    case (cap_axis)
      2'd0: begin cap_sat = sat[0]; cap_sgn = sgn[0]; end
      2'd1: begin cap_sat = sat[1]; cap_sgn = sgn[1]; end
      2'd2: begin cap_sat = sat[2]; cap_sgn = sgn[2]; end
      default: ;
    endcase
  end

  // Saturated axes bypass the divider: its quotient is only valid below 2.0.
  assign cap_ext = cap_sat ? 27'h2000000 : {1'b0, quotient};
  assign cap_val = cap_sgn ? (~cap_ext + 27'd1) : cap_ext;

  fixed_divide u_div (
    .clk      (clk_in),
    .dividend (op_a),
    .divisor  (op_d),
    .quotient (quotient)
  );

  always_ff @(posedge clk_in) begin
    if (accept) begin
      op_a  <= abs_x;
      op_d  <= w_in;
      mag_y <= abs_y;
      mag_z <= abs_z;
    end else if (state == S_ISSUE && cnt == 2'd1) begin
      op_a <= mag_y;
    end else if (state == S_ISSUE && cnt == 2'd2) begin
      op_a <= mag_z;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= S_IDLE;
      cnt              <= '0;
      sgn              <= '0;
      sat              <= '0;
      iss_valid        <= 1'b0;
      iss_axis         <= '0;
      tag              <= '0;
      vertex_ready_out <= 1'b0;
      ndc_valid_out    <= 1'b0;
      ndc_x_out        <= '0;
      ndc_y_out        <= '0;
      ndc_z_out        <= '0;
      clip_out         <= '0;
      degenerate_out   <= 1'b0;
    end else begin
      tag <= {tag[DIV_LATENCY-2:0], {iss_valid, iss_axis}};
      if (cap_valid) begin
        case (cap_axis)
          2'd0: ndc_x_out <= cap_val;
          2'd1: ndc_y_out <= cap_val;
          2'd2: ndc_z_out <= cap_val;
          default: ;
        endcase
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            vertex_ready_out <= 1'b0;
            sgn <= {z_in[23], y_in[23], x_in[23]};
            sat <= {abs_z > w_in, abs_y > w_in, abs_x > w_in};
            ndc_x_out      <= '0;
            ndc_y_out      <= '0;
            ndc_z_out      <= '0;
            clip_out       <= '0;
            degenerate_out <= degen_in;
            if (degen_in) begin
              state         <= S_OUTPUT;
              ndc_valid_out <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              iss_valid <= 1'b1;
              iss_axis  <= 2'd0;
              cnt       <= 2'd1;
            end
          end else begin
            vertex_ready_out <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (cnt == 2'd3) begin
            iss_valid <= 1'b0;
            state     <= S_WAIT;
          end else begin
            iss_axis <= cnt;
            cnt      <= cnt + 2'd1;
          end
        end
        S_WAIT: begin
          if (cap_valid && cap_axis == 2'd2) begin
            ndc_valid_out <= 1'b1;
            clip_out      <= sat;
            state         <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (ndc_ready_in) begin
            ndc_valid_out    <= 1'b0;
            vertex_ready_out <= 1'b1;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perspective_divide.sv
// Scoreboard bench for perspective_divide: directed corner vertices,
// stall/reset scenarios and a random sweep against an arithmetic model.
module tb_perspective_divide;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        vertex_valid_in;
  logic        vertex_ready_out;
  logic [23:0] x_in, y_in, z_in, w_in;
  logic        ndc_valid_out;
  logic        ndc_ready_in;
  logic [26:0] ndc_x_out, ndc_y_out, ndc_z_out;
  logic [2:0]  clip_out;
  logic        degenerate_out;

  typedef struct {
    logic [26:0] x;
    logic [26:0] y;
    logic [26:0] z;
    logic [2:0]  clip;
    logic        degen;
    int          lat;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   rise = 0;
  logic prev_v = 1'b0;

  perspective_divide #(.DIV_LATENCY(26)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .vertex_valid_in  (vertex_valid_in),
    .vertex_ready_out (vertex_ready_out),
    .x_in             (x_in),
    .y_in             (y_in),
    .z_in             (z_in),
    .w_in             (w_in),
    .ndc_valid_out    (ndc_valid_out),
    .ndc_ready_in     (ndc_ready_in),
    .ndc_x_out        (ndc_x_out),
    .ndc_y_out        (ndc_y_out),
    .ndc_z_out        (ndc_z_out),
    .clip_out         (clip_out),
    .degenerate_out   (degenerate_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(logic [26:0] x, logic [26:0] y,
                              logic [26:0] z, logic [2:0] clip,
                              logic degen, int lat);
    exp_t e;
    e.x = x; e.y = y; e.z = z;
    e.clip = clip; e.degen = degen;
    e.lat = lat; e.t = 0;
    return e;
  endfunction

  // NDC value of one coordinate: |c|/w as Q1.25, truncated, clamped to 1.0.
  function automatic logic [27:0] axis(logic [23:0] c, longint wv);
    longint cv, m, q;
    logic [26:0] v;
    logic cl;
    cv = longint'($signed(c));
    m  = (cv < 0) ? -cv : cv;
    cl = (m > wv);
    q  = cl ? (longint'(1) << 25) : ((m << 25) / wv);
    if (cv < 0) q = -q;
    v = q[26:0];
    return {cl, v};
  endfunction

  function automatic exp_t model(logic [23:0] x, logic [23:0] y,
                                 logic [23:0] z, logic [23:0] w);
    longint wv;
    logic [27:0] ax, ay, az;
    wv = longint'($signed(w));
    if (wv <= 0) return mk(0, 0, 0, 3'b000, 1'b1, 1);
    ax = axis(x, wv);
    ay = axis(y, wv);
    az = axis(z, wv);
    return mk(ax[26:0], ay[26:0], az[26:0],
              {az[27], ay[27], ax[27]}, 1'b0, 30);
  endfunction

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      if (ndc_valid_out && !prev_v) rise = cyc;
      if (ndc_valid_out && ndc_ready_in) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ndc_x", 32'(ndc_x_out), 32'(e.x));
          chk("ndc_y", 32'(ndc_y_out), 32'(e.y));
          chk("ndc_z", 32'(ndc_z_out), 32'(e.z));
          chk("clip", 32'(clip_out), 32'(e.clip));
          chk("degenerate", 32'(degenerate_out), 32'(e.degen));
          chk("latency", 32'(rise - e.t), 32'(e.lat));
        end
      end
    end
    prev_v = ndc_valid_out;
  end

  task automatic send(logic [23:0] x, logic [23:0] y,
                      logic [23:0] z, logic [23:0] w, exp_t e);
    int n = 0;
    @(posedge clk_in); #1;
    x_in = x; y_in = y; z_in = z; w_in = w;
    vertex_valid_in = 1'b1;
    while (!vertex_ready_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (!vertex_ready_out) begin
      chk("accept_timeout", 32'd0, 32'd1);
      vertex_valid_in = 1'b0;
      return;
    end
    e.t = cyc;
    sb.push_back(e);
    @(posedge clk_in); #1;
    vertex_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  function automatic logic [23:0] rand_coord(logic [23:0] w);
    int unsigned m;
    case ($urandom_range(0, 3))
      0: return 24'($urandom);
      1: m = 32'(w);
      default: m = $urandom_range(0, 32'(w));
    endcase
    return $urandom_range(0, 1) ? 24'(-int'(m)) : 24'(m);
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [26:0] sx, sy, sz;
    logic [2:0]  sc;
    logic        sd;
    logic        ok;
    int          n;
    logic [23:0] rw;
    rst_in = 1'b1;
    vertex_valid_in = 1'b0;
    ndc_ready_in = 1'b1;
    x_in = '0; y_in = '0; z_in = '0; w_in = '0;

    @(posedge clk_in); #1;
    chk("rst_ready", 32'(vertex_ready_out), 32'd0);
    chk("rst_valid", 32'(ndc_valid_out), 32'd0);
    chk("rst_outs", 32'(ndc_x_out | ndc_y_out | ndc_z_out), 32'd0);
    chk("rst_flags", 32'({clip_out, degenerate_out}), 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("ready_after_rst", 32'(vertex_ready_out), 32'd1);

    send(24'h080000, 24'hFC0000, 24'h100000, 24'h100000,
         mk(27'h1000000, 27'h7800000, 27'h2000000, 3'b000, 1'b0, 30));
    wait_idle();
    send(24'h200000, 24'hE00000, 24'h000000, 24'h100000,
         mk(27'h2000000, 27'h6000000, 27'h0, 3'b011, 1'b0, 30));
    wait_idle();
    send(24'h100000, 24'hF00000, 24'h800000, 24'h100000,
         mk(27'h2000000, 27'h6000000, 27'h6000000, 3'b100, 1'b0, 30));
    wait_idle();
    send(24'h000001, 24'hFFFFFF, 24'h000002, 24'h000003,
         mk(27'h0AAAAAA, 27'h7555556, 27'h1555555, 3'b000, 1'b0, 30));
    wait_idle();
    send(24'h123456, 24'h654321, 24'hABCDEF, 24'h000000,
         mk(27'h0, 27'h0, 27'h0, 3'b000, 1'b1, 1));
    wait_idle();
    send(24'h010000, 24'h020000, 24'h030000, 24'h800000,
         mk(27'h0, 27'h0, 27'h0, 3'b000, 1'b1, 1));
    wait_idle();

    // Downstream stall: everything must hold until ready returns.
    ndc_ready_in = 1'b0;
    send(24'h040000, 24'h040000, 24'h040000, 24'h100000,
         mk(27'h0800000, 27'h0800000, 27'h0800000, 3'b000, 1'b0, 30));
    n = 0;
    while (!ndc_valid_out && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("stall_valid_seen", 32'(ndc_valid_out), 32'd1);
    sx = ndc_x_out; sy = ndc_y_out; sz = ndc_z_out;
    sc = clip_out; sd = degenerate_out;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (!ndc_valid_out || vertex_ready_out || ndc_x_out != sx ||
          ndc_y_out != sy || ndc_z_out != sz || clip_out != sc ||
          degenerate_out != sd)
        ok = 1'b0;
    end
    chk("stall_stable", 32'(ok), 32'd1);
    ndc_ready_in = 1'b1;
    @(posedge clk_in); #1;
    chk("release_ready", 32'(vertex_ready_out), 32'd1);
    chk("release_valid", 32'(ndc_valid_out), 32'd0);
    wait_idle();

    // Reset in the middle of the divider wait drops the vertex.
    send(24'h0C0000, 24'hF40000, 24'h060000, 24'h100000,
         mk(27'h0, 27'h0, 27'h0, 3'b000, 1'b0, 30));
    repeat (9) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    sb.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    send(24'h040000, 24'h040000, 24'h040000, 24'h100000,
         mk(27'h0800000, 27'h0800000, 27'h0800000, 3'b000, 1'b0, 30));
    wait_idle();
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk_in); #1;
      if (ndc_valid_out) ok = 1'b0;
    end
    chk("no_stale_valid", 32'(ok), 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [23:0] rx, ry, rz;
      if ($urandom_range(0, 3) == 0) rw = 24'($urandom_range(1, 255));
      else rw = 24'($urandom_range(1, 32'h7FFFFF));
      rx = rand_coord(rw);
      ry = rand_coord(rw);
      rz = rand_coord(rw);
      send(rx, ry, rz, rw, model(rx, ry, rz, rw));
    end
    wait_idle();
    chk("queue_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
